tpu_array_ctrl: RTL and testbench
=================================

Name: tpu_array_ctrl

Overview:
Sequencer for a DIM x DIM systolic array of signed MAC cells. Each MAC cell has an accumulator write-enable, a compute enable, and registered pass-through of its A and B operands. This block performs one matrix-multiply pass in order: preload accumulators row by row, run the skewed compute window, then stream accumulator rows to a consumer. It sits between the host command interface and the array plus its A/B feeder buffers.

Parameters:
DIM, 4, array dimension (rows = cols), must be >= 2
BITS_AB, 8, A/B operand width; passed through to feeder, no internal use
BITS_C, 16, accumulator width; passed through, no internal use

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin pass; sampled only in IDLE
clear_c  in  1  sampled with start: 1 = preload zeros, 0 = preload host Cin
abort  in  1  return to IDLE next cycle from any state
rd_ready  in  1  consumer accepts current readout row
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of a successful pass
c_wr_en  out  DIM  one-hot row accumulator write enable (drives WrEn)
c_load_zero  out  1  latched clear_c; feeder drives Cin=0 when high
mac_en  out  1  compute enable to all cells
ab_step  out  clog2(3*DIM)  compute step index, 0..3*DIM-3
a_valid  out  DIM  per-row A injection valid (skewed)
b_valid  out  DIM  per-column B injection valid (skewed)
c_rd_row  out  clog2(DIM)  row index being read out
rd_valid  out  1  readout row valid

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n. Reset forces state IDLE, and all outputs and counters to 0.
- Reset and abort mid-operation: either clears the pass with no done pulse. Reset overrides abort.
- States: IDLE, LOADC, COMPUTE, READ, DONE.
- IDLE: start=1 and abort=0 -> LOADC; clear_c latched into c_load_zero. start with abort=1 is ignored.
- LOADC (DIM cycles): row counter r = 0..DIM-1; c_wr_en = 1<<r; mac_en=0. After r=DIM-1 -> COMPUTE.
- COMPUTE (3*DIM-2 cycles): mac_en=1; ab_step counts 0..3*DIM-3.
  - a_valid[i] = 1 iff i <= ab_step <= i+DIM-1; b_valid uses the same rule.
  - After ab_step=3*DIM-3 -> READ; ab_step returns to 0.
- READ: rd_valid=1, c_rd_row=r.
  - rd_ready=1 advances r.
  - rd_ready=0 holds c_rd_row and rd_valid unchanged.
  - Acceptance of row DIM-1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Outside their own state: c_wr_en, mac_en, a_valid, b_valid, rd_valid are 0.
- start while busy is ignored; no queueing.
- Latency with rd_ready held high: start sampled at edge 0; LOADC cycles 1..DIM; COMPUTE next 3*DIM-2 cycles; READ next DIM cycles; DONE the following cycle. Total 5*DIM-1 cycles including DONE.
- All counters saturate at their terminal value; no wrap beyond a state's terminal count.

Optional Feature:
TPU_CTRL_ACCUM_EN
- Defined: adds input port accumulate (1 bit), sampled with start. accumulate=1 skips LOADC (IDLE -> COMPUTE directly), so the array adds onto its existing accumulator contents. accumulate=0 behaves as the base design.
- Undefined: port absent; every pass executes LOADC.

Decomposition:
- Package tpu_ctrl_pkg:
  - state enum typedef (IDLE, LOADC, COMPUTE, READ, DONE)
  - function returning compute length (3*DIM-2)
  - function returning step width (clog2 of 3*DIM)
- One sub-module, tpu_skew_mask: combinational DIM-bit window decode from ab_step and mac_en; instantiated twice (a_valid, b_valid).

Test Plan:
- DIM=4, start+clear_c=1, rd_ready=1 -> c_wr_en 0001,0010,0100,1000 cycles 1-4 with c_load_zero=1; mac_en cycles 5-14; a_valid[3] high at ab_step 3..6; rd_valid rows 0-3 cycles 15-18; done pulse cycle 19; busy low cycle 20.
- rd_ready=0 for 3 cycles while c_rd_row=2 -> c_rd_row=2 and rd_valid=1 held; row 3 follows one cycle after rd_ready returns high; done one cycle after row 3 accepted.
- start pulsed again during COMPUTE -> ignored; exactly one done pulse; state sequence unchanged.
- abort at ab_step=5 -> next cycle IDLE, mac_en=0, a_valid=0, busy=0, no done; new start then runs a full pass.
- rst_n=0 for one cycle during LOADC row 2 -> next edge all outputs 0, state IDLE; start simultaneous with abort in IDLE -> stays IDLE.
- With TPU_CTRL_ACCUM_EN, start+accumulate=1 -> c_wr_en stays 0; mac_en high cycles 1-10; readout cycles 11-14; done cycle 15.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg: shared types and sizing helpers for the systolic-array sequencer.
// Contents: state_e (sequencer states), compute_len() (COMPUTE cycle count),
// step_width() (ab_step width).
// Optional build macro used elsewhere in this slice: TPU_CTRL_ACCUM_EN.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADC   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_READ    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Cycles needed for the skewed wavefront to cross a dim x dim array.
    function automatic int unsigned compute_len(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

    // Width of the compute step index.
    function automatic int unsigned step_width(input int unsigned dim);
        return $clog2(3 * dim);
    endfunction

endpackage

// File: rtl/tpu_array_ctrl_if.sv
// tpu_array_ctrl_if: host command, array control and readout signals of the
// systolic-array sequencer.
// Host -> ctrl : start, clear_c, abort, rd_ready, accumulate (TPU_CTRL_ACCUM_EN only)
// Ctrl -> host : busy, done, c_wr_en, c_load_zero, mac_en, ab_step,
//                a_valid, b_valid, c_rd_row, rd_valid
// Modports: master (host / feeder side), slave (sequencer).
interface tpu_array_ctrl_if
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned DIM = 4
) ();

    localparam int unsigned STEP_W = step_width(DIM);
    localparam int unsigned ROW_W  = $clog2(DIM);

    logic              start;
    logic              clear_c;
    logic              abort;
    logic              rd_ready;
`ifdef TPU_CTRL_ACCUM_EN
    logic              accumulate;
`endif
    logic              busy;
    logic              done;
    logic [DIM-1:0]    c_wr_en;
    logic              c_load_zero;
    logic              mac_en;
    logic [STEP_W-1:0] ab_step;
    logic [DIM-1:0]    a_valid;
    logic [DIM-1:0]    b_valid;
    logic [ROW_W-1:0]  c_rd_row;
    logic              rd_valid;

    modport master (
        output start, clear_c, abort, rd_ready,
`ifdef TPU_CTRL_ACCUM_EN
        output accumulate,
`endif
        input  busy, done, c_wr_en, c_load_zero, mac_en, ab_step,
        input  a_valid, b_valid, c_rd_row, rd_valid
    );

    modport slave (
        input  start, clear_c, abort, rd_ready,
`ifdef TPU_CTRL_ACCUM_EN
        input  accumulate,
`endif
        output busy, done, c_wr_en, c_load_zero, mac_en, ab_step,
        output a_valid, b_valid, c_rd_row, rd_valid
    );

endinterface

// File: rtl/tpu_skew_mask.sv
// tpu_skew_mask: combinational injection window for a skewed systolic feed.
// Ports: step (compute step index), en (compute enable),
//        mask (bit i high while i <= step <= i+DIM-1 and en is high).
module tpu_skew_mask
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned DIM = 4
) (
    input  logic [step_width(DIM)-1:0] step,
    input  logic                       en,
    output logic [DIM-1:0]             mask
);

    // Lane i is fed for DIM consecutive steps starting at step i.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            mask[i] = en && (int'(step) >= i) && (int'(step) <= i + int'(DIM) - 1);
        end
    end

endmodule

// File: rtl/tpu_array_ctrl.sv
// tpu_array_ctrl: one matrix-multiply pass over a DIM x DIM systolic array:
// accumulator preload (LOADC), skewed compute window (COMPUTE), row readout
// (READ), completion pulse (DONE).
// Ports: clk, rst_n (synchronous, active-low), bus (tpu_array_ctrl_if.slave).
// Optional macro TPU_CTRL_ACCUM_EN: adds bus.accumulate; when sampled high with
// start the pass skips LOADC and adds onto the existing accumulators.
// BITS_AB / BITS_C only describe the attached datapath.
module tpu_array_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned DIM     = 4,
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tpu_array_ctrl_if.slave  bus
);

    localparam int unsigned STEP_W    = step_width(DIM);
    localparam int unsigned ROW_W     = $clog2(DIM);
    localparam int unsigned LAST_STEP = compute_len(DIM) - 1;

    if (DIM < 2 || BITS_AB < 1 || BITS_C < 1) begin : g_param_check
        $error("tpu_array_ctrl: invalid parameters");
    end

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIM-1:0]    c_wr_en_q, c_wr_en_d;
    logic              c_load_zero_q, c_load_zero_d;
    logic              mac_en_q, mac_en_d;
    logic [DIM-1:0]    a_valid_q, a_valid_d;
    logic [DIM-1:0]    b_valid_q, b_valid_d;
    logic [ROW_W-1:0]  c_rd_row_q, c_rd_row_d;
    logic              rd_valid_q, rd_valid_d;

    // Injection windows decoded from the next step so they register with it.
    tpu_skew_mask #(.DIM(DIM)) u_a_mask (.step(step_d), .en(mac_en_d), .mask(a_valid_d));
    tpu_skew_mask #(.DIM(DIM)) u_b_mask (.step(step_d), .en(mac_en_d), .mask(b_valid_d));

    // Next state, counters, and outputs decoded from the next state.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        step_d        = step_q;
        c_load_zero_d = c_load_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    c_load_zero_d = bus.clear_c;
                    row_d         = '0;
                    step_d        = '0;
`ifdef TPU_CTRL_ACCUM_EN
                    state_d       = bus.accumulate ? ST_COMPUTE : ST_LOADC;
`else
                    state_d       = ST_LOADC;
`endif
                end
            end
            ST_LOADC: begin
                if (row_q == ROW_W'(DIM - 1)) begin
                    state_d = ST_COMPUTE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_COMPUTE: begin
                if (step_q == STEP_W'(LAST_STEP)) begin
                    state_d = ST_READ;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_READ: begin
                if (bus.rd_ready) begin
                    if (row_q == ROW_W'(DIM - 1)) begin
                        state_d = ST_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the pass from any state; the latched clear flag is kept.
        if (bus.abort) begin
            state_d = ST_IDLE;
            row_d   = '0;
            step_d  = '0;
        end

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        c_wr_en_d  = (state_d == ST_LOADC) ? (DIM'(1) << row_d) : '0;
        mac_en_d   = (state_d == ST_COMPUTE);
        rd_valid_d = (state_d == ST_READ);
        c_rd_row_d = (state_d == ST_READ) ? row_d : '0;
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            step_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            c_wr_en_q     <= '0;
            c_load_zero_q <= 1'b0;
            mac_en_q      <= 1'b0;
            a_valid_q     <= '0;
            b_valid_q     <= '0;
            c_rd_row_q    <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            step_q        <= step_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            c_wr_en_q     <= c_wr_en_d;
            c_load_zero_q <= c_load_zero_d;
            mac_en_q      <= mac_en_d;
            a_valid_q     <= a_valid_d;
            b_valid_q     <= b_valid_d;
            c_rd_row_q    <= c_rd_row_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // The step counter is zero outside COMPUTE, so it drives ab_step directly.
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.c_wr_en     = c_wr_en_q;
    assign bus.c_load_zero = c_load_zero_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.ab_step     = step_q;
    assign bus.a_valid     = a_valid_q;
    assign bus.b_valid     = b_valid_q;
    assign bus.c_rd_row    = c_rd_row_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_tpu_array_ctrl.sv
// tb_tpu_array_ctrl: self-checking bench for tpu_array_ctrl (DIM=4).
// Per-cycle output vectors are compared against a phase model; accepted
// readout rows are checked against a scoreboard queue filled at start.
module tb_tpu_array_ctrl;
    import tpu_ctrl_pkg::*;

    localparam int unsigned DIM = 4;
    localparam int unsigned SW  = step_width(DIM);
    localparam int unsigned RW  = $clog2(DIM);

    typedef enum int {P_IDLE, P_LOAD, P_COMP, P_READ, P_DONE} phase_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_array_ctrl_if #(.DIM(DIM)) bus ();

    tpu_array_ctrl #(.DIM(DIM), .BITS_AB(8), .BITS_C(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int exp_rows[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pack_act();
        return 32'({bus.busy, bus.done, bus.c_wr_en, bus.c_load_zero, bus.mac_en,
                    bus.ab_step, bus.a_valid, bus.b_valid, bus.c_rd_row, bus.rd_valid});
    endfunction

    function automatic logic [31:0] pack_exp(input phase_e ph, input int r, input int s, input bit lz);
        logic [DIM-1:0] wr;
        logic [DIM-1:0] win;
        logic [SW-1:0]  st;
        logic [RW-1:0]  row;
        wr  = '0;
        win = '0;
        st  = '0;
        row = '0;
        if (ph == P_LOAD) wr[r] = 1'b1;
        if (ph == P_COMP) begin
            st = SW'(s);
            for (int i = 0; i < int'(DIM); i++) win[i] = (s >= i) && (s < i + int'(DIM));
        end
        if (ph == P_READ) row = RW'(r);
        return 32'({ph != P_IDLE, ph == P_DONE, wr, lz, ph == P_COMP, st, win, win, row, ph == P_READ});
    endfunction

    // One pass; abort_at < 0 means no abort, stall_len cycles of rd_ready=0 at stall_row.
    task automatic run_pass(input bit clr, input bit acc, input int stall_row, input int stall_len,
                            input bit poke, input int abort_at);
        phase_e ph;
        int r       = 0;
        int s       = 0;
        int stalled = 0;
        int done_k  = -1;
        int k;
        bit ab;
        n_done = 0;
        exp_rows.delete();
        if (abort_at < 0) for (int i = 0; i < int'(DIM); i++) exp_rows.push_back(i);
        bus.start    = 1'b1;
        bus.clear_c  = clr;
        bus.abort    = 1'b0;
        bus.rd_ready = 1'b1;
`ifdef TPU_CTRL_ACCUM_EN
        bus.accumulate = acc;
`endif
        ph = acc ? P_COMP : P_LOAD;
        tick();
        bus.clear_c = 1'b0;
`ifdef TPU_CTRL_ACCUM_EN
        bus.accumulate = 1'b0;
`endif
        for (k = 1; k < 200; k++) begin
            ab           = (ph == P_COMP) && (s == abort_at);
            bus.abort    = ab;
            bus.start    = poke && (ph == P_COMP) && (s == 3);
            bus.rd_ready = 1'b1;
            if (ph == P_READ && r == stall_row && stalled < stall_len) begin
                bus.rd_ready = 1'b0;
                stalled++;
            end
            check_val($sformatf("vec_k%0d", k), pack_act(), pack_exp(ph, r, s, clr));
            if (ph == P_COMP && (s == 2 || s == 3 || s == 6 || s == 7))
                check_val($sformatf("a_valid3_s%0d", s), 32'(bus.a_valid[3]), 32'(s >= 3 && s <= 6));
            if (bus.done) begin
                n_done++;
                done_k = k;
                check_val("sb_drained", 32'(exp_rows.size()), 32'd0);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rows.size() == 0) check_val("sb_unexpected_row", 32'(bus.c_rd_row), 32'hffff_ffff);
                else check_val("rd_row", 32'(bus.c_rd_row), 32'(exp_rows.pop_front()));
            end
            if (ph == P_IDLE) break;
            if (ab) begin
                ph = P_IDLE;
            end else begin
                case (ph)
                    P_LOAD: if (r == int'(DIM) - 1) begin ph = P_COMP; r = 0; end else r++;
                    P_COMP: if (s == 3 * int'(DIM) - 3) begin ph = P_READ; s = 0; r = 0; end else s++;
                    P_READ: if (bus.rd_ready) begin
                                if (r == int'(DIM) - 1) ph = P_DONE; else r++;
                            end
                    P_DONE: ph = P_IDLE;
                    default: ;
                endcase
            end
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (k >= 200) check_val("timeout", 32'(k), 32'd0);
        check_val("done_count", 32'(n_done), (abort_at < 0) ? 32'd1 : 32'd0);
        if (stall_len == 0 && abort_at < 0)
            check_val("done_cycle", 32'(done_k), acc ? 32'(4 * DIM - 1) : 32'(5 * DIM - 1));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.clear_c  = 1'b0;
        bus.abort    = 1'b0;
        bus.rd_ready = 1'b0;
`ifdef TPU_CTRL_ACCUM_EN
        bus.accumulate = 1'b0;
`endif
        tick();
        tick();
        check_val("reset_state", pack_act(), 32'd0);
        rst_n = 1'b1;
        tick();

        run_pass(1'b1, 1'b0, -1, 0, 1'b0, -1);   // clear preload, ready held high
        run_pass(1'b0, 1'b0,  2, 3, 1'b0, -1);   // readout stall on row 2
        run_pass(1'b1, 1'b0, -1, 0, 1'b1, -1);   // start poked during COMPUTE
        run_pass(1'b0, 1'b0, -1, 0, 1'b0,  5);   // abort at ab_step 5
        run_pass(1'b1, 1'b0, -1, 0, 1'b0, -1);   // full pass after abort

        // Reset during LOADC row 2.
        bus.start   = 1'b1;
        bus.clear_c = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.clear_c = 1'b0;
        tick();
        tick();
        check_val("loadc_row2", 32'(bus.c_wr_en), 32'h4);
        rst_n = 1'b0;
        tick();
        check_val("mid_reset", pack_act(), 32'd0);
        rst_n = 1'b1;

        // start together with abort in IDLE is ignored.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_val("start_abort_idle", pack_act(), 32'd0);
        tick();
        check_val("still_idle", pack_act(), 32'd0);

        run_pass(1'b0, 1'b0, -1, 0, 1'b0, -1);
`ifdef TPU_CTRL_ACCUM_EN
        run_pass(1'b0, 1'b1, -1, 0, 1'b0, -1);   // accumulate skips LOADC
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
